// File: rtl/alu_wb_buffer_if.sv
// Handshake and flag bus between the ALU, the writeback buffer and its consumers.
// The buffer attaches through the slave modport; the driving side uses master.
interface alu_wb_buffer_if #(
  parameter int unsigned RW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_res;
  logic [3:0]    in_szcv;
  logic [3:0]    in_op;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          in_fe;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_res;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic [3:0]    flags;
  logic [2:0]    br_cond;
  logic          br_taken;

  modport master (
    output in_valid, in_res, in_szcv, in_op, in_rd, in_we, in_fe, flush,
           out_ready, br_cond,
    input  in_ready, out_valid, out_res, out_rd, out_we, flags, br_taken
  );

  modport slave (
    input  in_valid, in_res, in_szcv, in_op, in_rd, in_we, in_fe, flush,
           out_ready, br_cond,
    output in_ready, out_valid, out_res, out_rd, out_we, flags, br_taken
  );
endinterface

// File: rtl/alu_wb_buffer.sv
// Two-entry in-order ALU result buffer feeding register writeback, plus the
// architectural S/Z/C/V flag register and branch-condition evaluation.
module alu_wb_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RW    = 3
) (
  input logic             clk,
  input logic             rst_n,
  alu_wb_buffer_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DW    = 16;

  logic             r_head;
  logic             r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DW-1:0]    r_res [DEPTH];
  logic [RW-1:0]    r_rd  [DEPTH];
  logic             r_we  [DEPTH];
  logic [3:0]       r_flags;

  logic w_push;
  logic w_pop;
  logic w_in_ready;
  logic w_out_valid;
  logic w_v_ok;
  logic w_s;
  logic w_z;
  logic w_v;
  logic w_br_taken;

  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != CNT_W'(0));
  assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

  // Only ADD/SUB/CMP produce a defined overflow bit; elsewhere V is forced to 0
  assign w_v_ok = (bus.in_op == 4'b0000) || (bus.in_op == 4'b0001) ||
                  (bus.in_op == 4'b0101);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
      r_flags <= 4'b0000;
      for (int i = 0; i < DEPTH; i++) begin
        r_res[i] <= '0;
        r_rd[i]  <= '0;
        r_we[i]  <= 1'b0;
      end
    end else if (bus.flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_res[r_tail] <= bus.in_res;
        r_rd[r_tail]  <= bus.in_rd;
        r_we[r_tail]  <= bus.in_we;
        r_tail        <= ~r_tail;
        if (bus.in_fe) begin
          r_flags <= {bus.in_szcv[3:1], bus.in_szcv[0] & w_v_ok};
        end
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Branch resolution straight from the architectural flags (no bypass)
  assign w_s = r_flags[3];
  assign w_z = r_flags[2];
  assign w_v = r_flags[0];

  always_comb begin
    w_br_taken = 1'b0;
    case (bus.br_cond)
      3'b000:  w_br_taken = w_z;
      3'b001:  w_br_taken = w_s ^ w_v;
      3'b010:  w_br_taken = w_z | (w_s ^ w_v);
      3'b011:  w_br_taken = ~w_z;
      3'b111:  w_br_taken = 1'b1;
      default: w_br_taken = 1'b0;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_res   = r_res[r_head];
  assign bus.out_rd    = r_rd[r_head];
  assign bus.out_we    = r_we[r_head];
  assign bus.flags     = r_flags;
  assign bus.br_taken  = w_br_taken;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed and randomized bench for alu_wb_buffer against a queue-based
// model of the buffer and flag register.
module tb_alu_wb_buffer;
  localparam int unsigned RW = 3;

  typedef struct {
    logic [15:0]   res;
    logic [RW-1:0] rd;
    logic          we;
  } entry_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  entry_t      q[$];
  logic [3:0]  mflags;

  alu_wb_buffer_if #(.RW(RW)) bus ();

  alu_wb_buffer #(.DEPTH(2), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic br_model(input logic [3:0] f, input logic [2:0] c);
    logic s, z, v;
    s = f[3]; z = f[2]; v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return s != v;
      3'd2: return z || (s != v);
      3'd3: return !z;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic v_defined(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd5);
  endfunction

  // Compare visible outputs with the model, clock once, then advance the model.
  task automatic step();
    bit     push, pop;
    entry_t e;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("flags", 32'(bus.flags), 32'(mflags));
    chk("br_taken", 32'(bus.br_taken), 32'(br_model(mflags, bus.br_cond)));
    if (q.size() > 0) begin
      chk("out_res", 32'(bus.out_res), 32'(q[0].res));
      chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
      chk("out_we", 32'(bus.out_we), 32'(q[0].we));
    end
    push = bus.in_valid && (q.size() < 2) && !bus.flush;
    pop  = (q.size() > 0) && bus.out_ready && !bus.flush;
    e.res = bus.in_res; e.rd = bus.in_rd; e.we = bus.in_we;
    @(posedge clk);
    if (bus.flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (bus.in_fe)
          mflags = {bus.in_szcv[3:1], bus.in_szcv[0] && v_defined(bus.in_op)};
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] res, input logic [RW-1:0] rd,
                       input logic we, input logic fe, input logic [3:0] op,
                       input logic [3:0] szcv);
    bus.in_valid = v; bus.in_res = res; bus.in_rd = rd; bus.in_we = we;
    bus.in_fe = fe; bus.in_op = op; bus.in_szcv = szcv;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    q.delete(); mflags = 4'b0000;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    bus.flush = 1'b0; bus.out_ready = 1'b0; bus.br_cond = 3'b000;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_out_res", 32'(bus.out_res), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_we", 32'(bus.out_we), 32'd0);
    chk("rst_br_be", 32'(bus.br_taken), 32'd0);
    bus.br_cond = 3'b111; #1;
    chk("rst_br_b", 32'(bus.br_taken), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single push, then BLT off S=0,V=1
    drive(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 4'b0000, 4'b0001);
    bus.br_cond = 3'b001;
    step();
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("single_out_res", 32'(bus.out_res), 32'h1234);
    chk("single_flags", 32'(bus.flags), 32'h1);
    chk("single_blt", 32'(bus.br_taken), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Fill, third push ignored, then drain in order
    drive(1'b1, 16'h0001, 3'd1, 1'b1, 1'b0, 4'h2, 4'h0); step();
    drive(1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 4'h2, 4'h0); step();
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h0003, 3'd4, 1'b0, 1'b1, 4'h0, 4'hF); step();
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    bus.out_ready = 1'b1;
    chk("drain_a", 32'(bus.out_res), 32'h0001); step();
    chk("drain_b", 32'(bus.out_res), 32'h0002); step();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);
    chk("drain_ready", 32'(bus.in_ready), 32'd1);

    // Streaming at count 1 across pointer wraps
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(16'hA000 + i), 3'(i), 1'(i), 1'b0, 4'h3, 4'h0);
      bus.br_cond = 3'($urandom_range(0, 7));
      step();
    end
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    step();

    // V masking on AND
    drive(1'b1, 16'h5555, 3'd5, 1'b1, 1'b1, 4'b0010, 4'b0101);
    step();
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("vmask_flags", 32'(bus.flags), 32'h4);
    bus.br_cond = 3'b000; #1;
    chk("vmask_be", 32'(bus.br_taken), 32'd1);
    bus.br_cond = 3'b011; #1;
    chk("vmask_bne", 32'(bus.br_taken), 32'd0);
    step();

    // Flush with two entries and a flag-setting input
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 4'h0, 4'h0); step();
    drive(1'b1, 16'h2222, 3'd2, 1'b1, 1'b0, 4'h0, 4'h0); step();
    drive(1'b1, 16'h3333, 3'd3, 1'b1, 1'b1, 4'h0, 4'hB);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_flags", 32'(bus.flags), 32'h4);
    step();

    // Asynchronous reset with one entry pending
    drive(1'b1, 16'h7777, 3'd7, 1'b1, 1'b1, 4'h1, 4'hB); step();
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_flags", 32'(bus.flags), 32'd0);
    q.delete(); mflags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.flush     = 1'($urandom_range(0, 19) == 0);
      bus.br_cond   = 3'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
